// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel edge detector: two line buffers feed a 3x3 window, followed by
// a column-intermediate stage and a gradient/mode stage, with valid/ready backpressure.
module sobel_stream_engine #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_sof,
    input  logic [1:0]       mode,
    input  logic [PIX_W+2:0] threshold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_eol,
    output logic             out_eof
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int GW = PIX_W + 3;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [GW-1:0] PIX_MAX  = GW'((1 << PIX_W) - 1);

    function automatic logic [PIX_W+1:0] col_sum(input logic [PIX_W-1:0] t,
                                                 input logic [PIX_W-1:0] m,
                                                 input logic [PIX_W-1:0] b);
        return {2'b00, t} + {1'b0, m, 1'b0} + {2'b00, b};
    endfunction

    function automatic logic signed [PIX_W:0] col_diff(input logic [PIX_W-1:0] t,
                                                       input logic [PIX_W-1:0] b);
        return $signed({1'b0, t}) - $signed({1'b0, b});
    endfunction

    function automatic logic signed [GW-1:0] sext_d(input logic signed [PIX_W:0] d);
        return {{2{d[PIX_W]}}, d};
    endfunction

    function automatic logic [PIX_W+1:0] abs_grad(input logic signed [GW-1:0] v);
        return (PIX_W+2)'(v[GW-1] ? -v : v);
    endfunction

    function automatic logic [PIX_W-1:0] sat_pix(input logic [GW-1:0] v);
        return (v > PIX_MAX) ? {PIX_W{1'b1}} : v[PIX_W-1:0];
    endfunction

    logic             advance;
    logic             accept;
    logic             launch;
    logic [CW-1:0]    col;
    logic [CW-1:0]    col_cur;
    logic [RW-1:0]    row;
    logic [RW-1:0]    row_cur;
    logic [1:0]       mode_q;
    logic [PIX_W+2:0] thr_q;

    logic [PIX_W-1:0] lb_top [IMG_W];
    logic [PIX_W-1:0] lb_mid [IMG_W];

    logic [2:0][PIX_W-1:0] win_t_p0;
    logic [2:0][PIX_W-1:0] win_m_p0;
    logic [2:0][PIX_W-1:0] win_b_p0;
    logic                  vld_p0;
    logic                  eol_p0;
    logic                  eof_p0;
    logic [1:0]            mode_p0;
    logic [PIX_W+2:0]      thr_p0;

    logic [PIX_W+1:0]        c_l_p1;
    logic [PIX_W+1:0]        c_r_p1;
    logic signed [PIX_W:0]   d_l_p1;
    logic signed [PIX_W:0]   d_m_p1;
    logic signed [PIX_W:0]   d_r_p1;
    logic                    vld_p1;
    logic                    eol_p1;
    logic                    eof_p1;
    logic [1:0]              mode_p1;
    logic [PIX_W+2:0]        thr_p1;

    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
    logic [PIX_W+1:0]     abs_x;
    logic [PIX_W+1:0]     abs_y;
    logic [GW-1:0]        mag;
    logic [PIX_W-1:0]     result;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;
    // A start-of-frame pixel is placed at (0,0) regardless of where the counters were.
    assign col_cur  = in_sof ? '0 : col;
    assign row_cur  = in_sof ? '0 : row;
    assign launch   = (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            mode_q    <= '0;
            thr_q     <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (advance) begin
            if (accept) begin
                if (col_cur == COL_LAST) begin
                    col <= '0;
                    row <= (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
                end else begin
                    col <= col_cur + 1'b1;
                    row <= row_cur;
                end
                if (in_sof) begin
                    mode_q <= mode;
                    thr_q  <= threshold;
                end
            end
            vld_p0    <= accept && launch;
            vld_p1    <= vld_p0;
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_pixel <= result;
                out_eol   <= eol_p1;
                out_eof   <= eof_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // p0: line buffers rotate and the window shifts one column left
        if (accept) begin
            lb_top[col_cur] <= lb_mid[col_cur];
            lb_mid[col_cur] <= in_pixel;
            win_t_p0 <= {lb_top[col_cur], win_t_p0[2:1]};
            win_m_p0 <= {lb_mid[col_cur], win_m_p0[2:1]};
            win_b_p0 <= {in_pixel, win_b_p0[2:1]};
            eol_p0   <= (col_cur == COL_LAST);
            eof_p0   <= (col_cur == COL_LAST) && (row_cur == ROW_LAST);
            mode_p0  <= mode_q;
            thr_p0   <= thr_q;
        end
        // p1: per-column intermediates; the centre column sum has zero Gx weight
        if (advance) begin
            c_l_p1  <= col_sum(win_t_p0[0], win_m_p0[0], win_b_p0[0]);
            c_r_p1  <= col_sum(win_t_p0[2], win_m_p0[2], win_b_p0[2]);
            d_l_p1  <= col_diff(win_t_p0[0], win_b_p0[0]);
            d_m_p1  <= col_diff(win_t_p0[1], win_b_p0[1]);
            d_r_p1  <= col_diff(win_t_p0[2], win_b_p0[2]);
            eol_p1  <= eol_p0;
            eof_p1  <= eof_p0;
            mode_p1 <= mode_p0;
            thr_p1  <= thr_p0;
        end
    end

    // p2: gradients, magnitude and output mode selection
    always_comb begin
        gx     = $signed({1'b0, c_r_p1}) - $signed({1'b0, c_l_p1});
        gy     = sext_d(d_l_p1) + (sext_d(d_m_p1) <<< 1) + sext_d(d_r_p1);
        abs_x  = abs_grad(gx);
        abs_y  = abs_grad(gy);
        mag    = {1'b0, abs_x} + {1'b0, abs_y};
        result = '0;
        case (mode_p1)
            2'd0:    result = sat_pix(mag);
            2'd1:    result = sat_pix({1'b0, abs_x});
            2'd2:    result = sat_pix({1'b0, abs_y});
            default: result = (mag >= thr_p1) ? {PIX_W{1'b1}} : '0;
        endcase
    end

endmodule

// File: tb/tb_sobel_stream_engine.sv
// Scenario bench for sobel_stream_engine at 8x6 with a reference Sobel model and
// an output scoreboard queue.
module tb_sobel_stream_engine;

    localparam int PW = 8;
    localparam int W  = 8;
    localparam int H  = 6;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pixel;
    logic          in_sof;
    logic [1:0]    mode;
    logic [PW+2:0] threshold;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pixel;
    logic          out_eol;
    logic          out_eof;

    sobel_stream_engine #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
        .mode(mode), .threshold(threshold),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_eol(out_eol), .out_eof(out_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int out_cnt = 0;
    int cyc = 0;
    logic [9:0] sb_q[$];
    logic [7:0] out_log[$];
    int frame_buf[H][W];

    int img[H][W];
    int m_col = 0;
    int m_row = 0;
    int m_mode = 0;
    int m_thr = 0;

    task automatic model_accept(input logic [7:0] p, input logic sof,
                                input logic [1:0] md, input logic [10:0] th);
        int r, c, gx, gy, ax, ay, s, res;
        if (sof) begin
            m_col = 0; m_row = 0; m_mode = int'(md); m_thr = int'(th);
        end
        r = m_row; c = m_col;
        img[r][c] = int'(p);
        if (r >= 2 && c >= 2) begin
            gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
               - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
            gy = (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c])
               - (img[r][c-2] + 2*img[r][c-1] + img[r][c]);
            ax = (gx < 0) ? -gx : gx;
            ay = (gy < 0) ? -gy : gy;
            s  = ax + ay;
            case (m_mode)
                0: res = (s > 255) ? 255 : s;
                1: res = (ax > 255) ? 255 : ax;
                2: res = (ay > 255) ? 255 : ay;
                default: res = (s >= m_thr) ? 255 : 0;
            endcase
            sb_q.push_back({8'(res), (c == W-1), (c == W-1) && (r == H-1)});
        end
        if (c == W-1) begin
            m_col = 0;
            m_row = (r == H-1) ? 0 : r + 1;
        end else begin
            m_col = c + 1;
        end
    endtask

    task automatic tick(output bit acc);
        logic [9:0] exp_v;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            out_cnt++;
            out_log.push_back(out_pixel);
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: got pix=%0d eol=%b eof=%b, required no output",
                         out_pixel, out_eol, out_eof);
            end else begin
                exp_v = sb_q.pop_front();
                if ({out_pixel, out_eol, out_eof} !== exp_v) begin
                    tests_failed++;
                    $display("FAIL sb_output #%0d: got pix=%0d eol=%b eof=%b, required pix=%0d eol=%b eof=%b",
                             out_cnt, out_pixel, out_eol, out_eof, exp_v[9:2], exp_v[1], exp_v[0]);
                end
            end
        end
        if (acc) model_accept(in_pixel, in_sof, mode, threshold);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [7:0] p, input logic sof,
                              input logic [1:0] md, input logic [10:0] th);
        bit acc;
        int guard;
        guard = 0;
        in_valid  = 1'b1;
        in_pixel  = p;
        in_sof    = sof;
        mode      = sof ? md : 2'($urandom);
        threshold = sof ? th : 11'($urandom);
        do begin
            tick(acc);
            guard++;
        end while (!acc && guard < 50);
        if (!acc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", guard);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] md, input logic [10:0] th,
                              input bit first_sof, input int n_pix);
        for (int i = 0; i < n_pix; i++)
            send_pixel(8'(frame_buf[i / W][i % W]), first_sof && (i == 0), md, th);
    endtask

    task automatic drain();
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick(acc);
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frame_buf[r][c] = int'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_pixel = '0; in_sof = 1'b0; mode = '0; threshold = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        tests_run += 5;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        if (out_pixel !== 8'd0) begin tests_failed++; $display("FAIL reset_out_pixel: got %0d, required 0", out_pixel); end
        if (out_eol !== 1'b0) begin tests_failed++; $display("FAIL reset_out_eol: got %b, required 0", out_eol); end
        if (out_eof !== 1'b0) begin tests_failed++; $display("FAIL reset_out_eof: got %b, required 0", out_eof); end
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flat();
        int c0, n0;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame_buf[r][c] = 100;
        out_log.delete();
        n0 = out_cnt;
        c0 = cyc;
        send_frame(2'd0, 11'd0, 1'b1, W*H);
        tests_run++;
        if (cyc - c0 !== W*H) begin
            tests_failed++;
            $display("FAIL flat_throughput: got %0d cycles for %0d pixels, required %0d", cyc - c0, W*H, W*H);
        end
        drain();
        tests_run += 2;
        if (out_cnt - n0 !== 24) begin tests_failed++; $display("FAIL flat_count: got %0d, required 24", out_cnt - n0); end
        if (sb_q.size() !== 0) begin tests_failed++; $display("FAIL flat_pending: got %0d left, required 0", sb_q.size()); end
    endtask

    task automatic test_known_window();
        int seed_l[3] = '{8, 60, 43};
        int seed_m[3] = '{32, 5, 241};
        int seed_r[3] = '{135, 225, 216};
        for (int md = 1; md <= 2; md++) begin
            fill_random();
            for (int r = 0; r < 3; r++) begin
                frame_buf[r][0] = seed_l[r];
                frame_buf[r][1] = seed_m[r];
                frame_buf[r][2] = seed_r[r];
            end
            out_log.delete();
            send_frame(2'(md), 11'd0, 1'b1, W*H);
            drain();
            tests_run++;
            if (out_log.size() == 0 || out_log[0] !== 8'd255) begin
                tests_failed++;
                $display("FAIL window_mode%0d: got %0d, required 255",
                         md, (out_log.size() == 0) ? -1 : int'(out_log[0]));
            end
        end
    endtask

    task automatic test_columns();
        int cc;
        logic [7:0] want;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame_buf[r][c] = (c < 4) ? 0 : 20;
        for (int pass = 0; pass < 2; pass++) begin
            out_log.delete();
            send_frame((pass == 0) ? 2'd0 : 2'd3, 11'd50, 1'b1, W*H);
            drain();
            tests_run++;
            if (out_log.size() !== 24) begin
                tests_failed++;
                $display("FAIL columns_count%0d: got %0d, required 24", pass, out_log.size());
            end else begin
                for (int k = 0; k < 24; k++) begin
                    cc = (k % 6) + 1;
                    want = (cc == 3 || cc == 4) ? ((pass == 0) ? 8'd80 : 8'd255) : 8'd0;
                    tests_run++;
                    if (out_log[k] !== want) begin
                        tests_failed++;
                        $display("FAIL columns_pass%0d_k%0d: got %0d, required %0d", pass, k, out_log[k], want);
                    end
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] h_pix;
        logic h_eol, h_eof;
        bit acc;
        int n0;
        fill_random();
        n0 = out_cnt;
        for (int i = 0; i < W*H; i++) begin
            send_pixel(8'(frame_buf[i / W][i % W]), i == 0, 2'd0, 11'd0);
            if (i == 20) begin
                tests_run++;
                if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_precond: got out_valid=%b, required 1", out_valid); end
                h_pix = out_pixel; h_eol = out_eol; h_eof = out_eof;
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_pixel  = 8'(frame_buf[21 / W][21 % W]);
                for (int k = 0; k < 5; k++) begin
                    tick(acc);
                    tests_run++;
                    if (acc || in_ready !== 1'b0 || out_valid !== 1'b1 ||
                        out_pixel !== h_pix || out_eol !== h_eol || out_eof !== h_eof) begin
                        tests_failed++;
                        $display("FAIL stall_hold_%0d: got acc=%b rdy=%b vld=%b pix=%0d eol=%b eof=%b, required acc=0 rdy=0 vld=1 pix=%0d eol=%b eof=%b",
                                 k, acc, in_ready, out_valid, out_pixel, out_eol, out_eof, h_pix, h_eol, h_eof);
                    end
                end
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
        end
        drain();
        tests_run += 2;
        if (out_cnt - n0 !== 24) begin tests_failed++; $display("FAIL stall_count: got %0d, required 24", out_cnt - n0); end
        if (sb_q.size() !== 0) begin tests_failed++; $display("FAIL stall_pending: got %0d left, required 0", sb_q.size()); end
    endtask

    task automatic test_sof_mid();
        int n0;
        fill_random();
        n0 = out_cnt;
        send_frame(2'd0, 11'd0, 1'b1, 3*W + 5);
        fill_random();
        send_frame(2'd1, 11'd0, 1'b1, W*H);
        drain();
        tests_run += 2;
        if (out_cnt - n0 !== 33) begin tests_failed++; $display("FAIL sof_count: got %0d, required 33", out_cnt - n0); end
        if (sb_q.size() !== 0) begin tests_failed++; $display("FAIL sof_pending: got %0d left, required 0", sb_q.size()); end
    endtask

    task automatic test_reset_mid();
        int n0;
        fill_random();
        send_frame(2'd2, 11'd0, 1'b1, 21);
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_precond: got out_valid=%b, required 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests_run += 2;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_async: got out_valid=%b, required 0", out_valid); end
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_in_ready: got %b, required 1", in_ready); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb_q.delete();
        m_col = 0; m_row = 0; m_mode = 0; m_thr = 0;
        fill_random();
        n0 = out_cnt;
        send_frame(2'd0, 11'd0, 1'b0, W*H);
        drain();
        tests_run += 2;
        if (out_cnt - n0 !== 24) begin tests_failed++; $display("FAIL rstmid_count: got %0d, required 24", out_cnt - n0); end
        if (sb_q.size() !== 0) begin tests_failed++; $display("FAIL rstmid_pending: got %0d left, required 0", sb_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_flat();
        test_known_window();
        test_columns();
        test_stall();
        test_sof_mid();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
